// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module : tdm_pkg
// Purpose: Shared constants and types for the 8-slot TDM transmitter.
//          Provides the slot count, slot-index width, the default idle
//          line level and the transmitter state enumeration.
// Rev    : 1.0  initial release
// ============================================================================
package tdm_pkg;

  localparam int   SLOTS              = 8;
  localparam int   SEL_W              = 3;
  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_t;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/mux8_1.sv
`default_nettype none
// ============================================================================
// Module : mux8_1
// Purpose: Combinational 8:1 bit selector.
// Ports  : data    [SLOTS-1:0] in  - word to select from
//          sel     [SEL_W-1:0] in  - bit index
//          bit_out             out - data[sel]
// Rev    : 1.0  initial release
// ============================================================================
module mux8_1
  import tdm_pkg::*;
(
  input  logic [SLOTS-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_out
);

  assign bit_out = data[sel];

endmodule : mux8_1
`default_nettype wire

// File: rtl/tdm_mux8_tx.sv
`default_nettype none
// ============================================================================
// Module : tdm_mux8_tx
// Purpose: TDM transmitter. Captures an 8-bit word on an accepted start and
//          sends bit k in slot k, one slot per clock, driving the serial line
//          and slot index of a downstream 1-to-8 demultiplexer.
// Ports  : clk    in   system clock, rising edge
//          rst    in   asynchronous active-high reset
//          start  in   frame request (ignored while busy)
//          d[7:0] in   parallel word, captured when start is accepted
//          stall  in   holds the current slot while high (SEND only)
//          sout   out  serial data, IDLE_LEVEL when no frame is in flight
//          sel    out  current slot index (demux select)
//          frame  out  frame sync, high in slot 0 of a frame
//          busy   out  frame in flight
//          done   out  one-cycle pulse in the first idle cycle after slot 7
// Rev    : 1.0  initial release
// ============================================================================
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SLOTS-1:0] d,
  input  logic             stall,
  output logic             sout,
  output logic [SEL_W-1:0] sel,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(SLOTS - 1);

  tdm_state_t       state, state_nxt;
  logic [SEL_W-1:0] sel_r, sel_nxt;
  logic [SLOTS-1:0] hold_reg, hold_nxt;
  logic             done_r, done_nxt;
  logic             slot_bit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_r    <= '0;
      hold_reg <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_r    <= sel_nxt;
      hold_reg <= hold_nxt;
      done_r   <= done_nxt;
    end
  end

  // Next-state logic. done is cleared by default, so it is high for exactly
  // the one cycle following the final unstalled slot-7 edge.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_r;
    hold_nxt  = hold_reg;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          hold_nxt  = d;
          sel_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!stall) begin
          if (sel_r == LAST_SLOT) begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            sel_nxt = sel_r + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  mux8_1 u_mux8_1 (
    .data    (hold_reg),
    .sel     (sel_r),
    .bit_out (slot_bit)
  );

  // Outputs depend on registered state only.
  assign busy  = (state == SEND);
  assign sel   = sel_r;
  assign frame = busy && (sel_r == '0);
  assign sout  = busy ? slot_bit : IDLE_LEVEL;
  assign done  = done_r;

endmodule : tdm_mux8_tx
`default_nettype wire

// File: tb/tb_tdm_mux8_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_tdm_mux8_tx
// Purpose: Directed self-checking bench for tdm_mux8_tx, including a model
//          of the downstream 1-to-8 demultiplexer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tdm_mux8_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d;
  logic       stall;
  logic       sout;
  logic [2:0] sel;
  logic       frame;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  tdm_mux8_tx #(.IDLE_LEVEL(1'b0)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .stall (stall),
    .sout  (sout),
    .sel   (sel),
    .frame (frame),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Demux model: s0 = sel[2], s1 = sel[1], s2 = sel[0]; line {s0,s1,s2} gets sout.
  logic       s0, s1, s2;
  logic [7:0] lines;
  assign s0    = sel[2];
  assign s1    = sel[1];
  assign s2    = sel[0];
  assign lines = {7'd0, sout} << {s0, s1, s2};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({sel, sout, frame, busy, done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", {sel, sout, frame, busy, done}, 7'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    stall = 1'b1;
    step();
    step();
    checks++;
    if ({sel, sout, frame, busy, done} !== 7'b0) begin
      failures++;
      $display("FAIL idle_stall: got %b expected %b", {sel, sout, frame, busy, done}, 7'b0);
    end
    stall = 1'b0;
  endtask

  task automatic test_basic();
    int exp_s[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    d = 8'b1011_0010;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({sel, sout, frame, busy, done} !== {3'(k), 1'(exp_s[k]), (k == 0), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL basic_slot%0d: got %b expected %b", k, {sel, sout, frame, busy, done},
                 {3'(k), 1'(exp_s[k]), (k == 0), 1'b1, 1'b0});
      end
      step();
    end
    checks++;
    if ({sel, sout, frame, busy, done} !== 7'b000_0001) begin
      failures++;
      $display("FAIL basic_done: got %b expected %b", {sel, sout, frame, busy, done}, 7'b000_0001);
    end
    step();
    checks++;
    if ({sout, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL basic_after_done: got %b expected %b", {sout, busy, done}, 3'b000);
    end
  endtask

  task automatic test_demux();
    logic [7:0] vals[3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] v;
    logic [7:0] exp_l;
    for (int i = 0; i < 3; i++) begin
      v = vals[i];
      d = v;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
        exp_l = v[k] ? (8'h01 << k) : 8'h00;
        checks++;
        if (lines !== exp_l) begin
          failures++;
          $display("FAIL demux_%h_slot%0d: got %b expected %b", v, k, lines, exp_l);
        end
        step();
      end
      checks++;
      if ({lines, done} !== 9'b0000_0000_1) begin
        failures++;
        $display("FAIL demux_%h_done: got %b expected %b", v, {lines, done}, 9'b0000_0000_1);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    // start held high; d disturbed mid-frame must not alter the frame.
    logic [7:0] a5 = 8'hA5;
    d = a5;
    start = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if ({sel, sout, busy, frame} !== {3'(k), a5[k], 1'b1, (k == 0)}) begin
          failures++;
          $display("FAIL repeat_f%0d_slot%0d: got %b expected %b", f, k,
                   {sel, sout, busy, frame}, {3'(k), a5[k], 1'b1, (k == 0)});
        end
        if (k == 3) d = 8'h3C;
        if (k == 7) d = a5;
        step();
      end
      checks++;
      if ({done, busy, sout} !== 3'b100) begin
        failures++;
        $display("FAIL repeat_f%0d_done: got %b expected %b", f, {done, busy, sout}, 3'b100);
      end
      if (f == 1) start = 1'b0;
      step();
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL repeat_stop: got %b expected %b", {busy, done}, 2'b00);
    end
  endtask

  task automatic test_stall();
    logic [7:0] f0 = 8'hF0;
    d = f0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({sel, sout, busy, done} !== {3'(k), f0[k], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL stall_slot%0d: got %b expected %b", k, {sel, sout, busy, done},
                 {3'(k), f0[k], 1'b1, 1'b0});
      end
      if (k == 4) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          checks++;
          if ({sel, sout, busy, done} !== 6'b100_110) begin
            failures++;
            $display("FAIL stall_hold%0d: got %b expected %b", s, {sel, sout, busy, done}, 6'b100_110);
          end
        end
        stall = 1'b0;
      end
      step();
    end
    checks++;
    if ({done, busy, sout} !== 3'b100) begin
      failures++;
      $display("FAIL stall_done: got %b expected %b", {done, busy, sout}, 3'b100);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [7:0] v = 8'h3C;
    d = 8'hC3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    checks++;
    if (sel !== 3'd5) begin
      failures++;
      $display("FAIL arst_pre: got %0d expected %0d", sel, 5);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel, sout, frame, busy, done} !== 7'b0) begin
      failures++;
      $display("FAIL arst_immediate: got %b expected %b", {sel, sout, frame, busy, done}, 7'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL arst_no_done%0d: got %b expected %b", i, {busy, done}, 2'b00);
      end
      step();
    end
    d = v;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({sel, sout, busy} !== {3'(k), v[k], 1'b1}) begin
        failures++;
        $display("FAIL arst_fresh_slot%0d: got %b expected %b", k, {sel, sout, busy}, {3'(k), v[k], 1'b1});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL arst_fresh_done: got %b expected %b", done, 1'b1);
    end
    step();
  endtask

  task automatic test_start_in_done();
    int exp_s[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    d = 8'h0F;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    checks++;
    if ({done, busy, sout} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_gap: got %b expected %b", {done, busy, sout}, 3'b100);
    end
    d = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({sel, sout, busy, done} !== {3'(k), 1'(exp_s[k]), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL b2b_slot%0d: got %b expected %b", k, {sel, sout, busy, done},
                 {3'(k), 1'(exp_s[k]), 1'b1, 1'b0});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: got %b expected %b", done, 1'b1);
    end
    step();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    d     = 8'h00;
    stall = 1'b0;
    test_reset();
    test_basic();
    test_demux();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_start_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tdm_mux8_tx
`default_nettype wire

// File: doc/tdm_mux8_tx.md
# tdm_mux8_tx

Time-division multiplexing transmitter: captures an 8-bit parallel word on a start request and serializes it onto a single line, one slot per clock, slot index 0..7. It is the transmit end for the existing 1-to-8 demultiplexer. Its slot index output drives that demultiplexer's select inputs, and its serial output drives the demultiplexer's data input, so slot k lands on output line k. The block owns the slot counter, frame timing and start/busy/done handshake.

## Interface
- IDLE_LEVEL, default 1'b0: level driven on sout when no frame is in flight
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame request, sampled on rising clk
- d  input  8  parallel word; bit k is sent in slot k; captured only when start is accepted
- stall  input  1  freezes the current slot (counter, sout, sel held) while high
- sout  output  1  serial data out
- sel  output  3  current slot index; sel[2] maps to demux s0, sel[1] to s1, sel[0] to s2
- frame  output  1  high while sel==0 and a frame is in flight (frame sync)
- busy  output  1  high while a frame is in flight
- done  output  1  one-cycle pulse after slot 7 completes

## Operation
- States: IDLE, SEND.
- IDLE:
  - busy=0, frame=0, sel=0, sout=IDLE_LEVEL.
  - If start=1, then at the edge: hold_reg<=d, sel<=0, state<=SEND.
- SEND:
  - busy=1, sout=hold_reg[sel], frame=(sel==0).
  - At each edge with stall=0: if sel<7 then sel<=sel+1. If sel==7 then state<=IDLE, sel<=0, done<=1.
  - At each edge with stall=1: all state holds. done is never asserted on a stalled edge.
- start while busy=1 is ignored, including during slot 7. d is not re-sampled mid-frame.
- done is high for exactly one cycle, the first IDLE cycle.
- start high in the done cycle is accepted, giving back-to-back frames separated by one IDLE_LEVEL cycle.
- stall is ignored in IDLE.
- Changes on d after acceptance have no effect on the in-flight frame.

## Timing
- Reset (async assert, any time):
  - state=IDLE, sel=0, hold_reg=0, done=0, busy=0, frame=0, sout=IDLE_LEVEL.
  - A frame in progress is discarded with no done pulse.
- Deassertion is synchronous to clk via the normal flop release. The first edge after release may accept start.
- Latency: start accepted at edge E. Slot k appears on sout/sel during the cycle after edge E+k, for k=0..7, with no stalls. done is high during the cycle after edge E+8.
- Each stalled cycle adds one cycle to the frame and to done latency.
- All outputs derive from registered state only. There is no combinational path from start, d or stall to any output.
- Frame length: 8 cycles plus stall count. Minimum start-to-start period: 9 cycles.

## Structure
- Package tdm_pkg:
  - SLOTS=8, SEL_W=3
  - state enumeration (IDLE, SEND)
  - IDLE_LEVEL default constant
- Sub-module mux8_1: combinational 8:1 selector (hold_reg, sel -> bit), instantiated once for sout.
- The slot counter and FSM stay in the top module.

## Test plan
- Reset, then start=1 for one cycle with d=8'b1011_0010: sout over 8 cycles = 0,1,0,0,1,1,0,1. sel counts 0..7. frame high in cycle 0 only. busy high 8 cycles. done one-cycle pulse, then sout=IDLE_LEVEL.
- Chain to the demux model, with d=8'h01, then 8'h80, then 8'hFF: demux output line k pulses exactly in slot k where d[k]=1. All other lines stay 0.
- start held high continuously with d=8'hA5: frames repeat every 9 cycles. start during busy is ignored. Each frame sends 8'hA5 even if d changes to 8'h3C mid-frame.
- stall=1 for 3 cycles during slot 4 of d=8'hF0: sel=4 and sout=1 are held for 4 cycles total. done arrives 3 cycles late. No slot is skipped or repeated after the stall.
- rst asserted mid-frame at slot 5, asynchronously between edges: outputs go to reset values immediately with no done. start after release sends a fresh frame from slot 0.
- start asserted in the done cycle with d=8'h5A: accepted. One IDLE_LEVEL gap cycle, then 0,1,0,1,1,0,1,0.
